// File: rtl/fft_frame_scheduler.sv
// Frame assembler and round-robin issuer for the fft_8point core; results are tagged with their source channel.
// Optional statistics counters are built only when FFT_SCHED_STATS_EN is defined.
module fft_frame_scheduler #(
    parameter int NUM_CH    = 2,
    parameter int TAG_DEPTH = 4,
    localparam int CH_W     = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     s_valid,
    output logic [NUM_CH-1:0]     s_ready,
    input  logic [NUM_CH*8-1:0]   s_data,
    output logic                  fft_s_valid,
    input  logic                  fft_s_ready,
    output logic [63:0]           fft_x,
    input  logic                  fft_m_valid,
    output logic                  fft_m_ready,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CH_W-1:0]       m_ch,
    output logic                  err_tag,
    output logic [15:0]           stat_frames,
    output logic [15:0]           stat_stall
);

    localparam int AW = $clog2(TAG_DEPTH);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   rr_ptr;
    logic [3:0]        cnt [NUM_CH];
    logic [7:0]        sbuf [NUM_CH][8];
    logic [NUM_CH-1:0] pend;
    logic              pick_found;
    logic [CH_W-1:0]   pick_ch;
    logic [CH_W-1:0]   idx_c;
    int                idx;

    logic [CH_W-1:0]   tag_mem [TAG_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       tag_cnt;
    logic              tag_full;
    logic              tag_empty;
    logic              push;
    logic              pop;

    assign tag_full  = (tag_cnt == (AW+1)'(TAG_DEPTH));
    assign tag_empty = (tag_cnt == '0);
    assign push      = (state == ISSUE) && fft_s_ready;
    assign pop       = fft_m_valid && m_ready && !tag_empty;

    assign fft_m_ready = m_ready;
    assign m_valid     = fft_m_valid;
    assign m_ch        = tag_empty ? '0 : tag_mem[rd_ptr];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            pend[c]    = (cnt[c] == 4'd8);
            s_ready[c] = !reset && (cnt[c] != 4'd8);
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            fft_x[8*i +: 8] = sbuf[grant][i];
        end
    end

    // Scan downward so the channel closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        idx        = 0;
        idx_c      = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            idx_c = CH_W'(idx);
            if (pend[idx_c]) begin
                pick_found = 1'b1;
                pick_ch    = idx_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            fft_s_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found && !tag_full) begin
                        grant       <= pick_ch;
                        state       <= ISSUE;
                        fft_s_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (fft_s_ready) begin
                        state       <= IDLE;
                        fft_s_valid <= 1'b0;
                        rr_ptr      <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A pending channel has s_ready low, so the issue clear never races a sample write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt[c] <= '0;
                for (int i = 0; i < 8; i++) begin
                    sbuf[c][i] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (s_valid[c] && s_ready[c]) begin
                    sbuf[c][cnt[c][2:0]] <= s_data[8*c +: 8];
                    cnt[c]               <= cnt[c] + 4'd1;
                end
            end
            if (push) begin
                cnt[grant] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
            err_tag <= 1'b0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= grant;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
            if (fft_m_valid && tag_empty) begin
                err_tag <= 1'b1;
            end
        end
    end

`ifdef FFT_SCHED_STATS_EN
    logic [15:0] frames_q;
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frames_q <= '0;
            stall_q  <= '0;
        end else begin
            if (push && frames_q != 16'hFFFF) begin
                frames_q <= frames_q + 16'd1;
            end
            if (state == ISSUE && !fft_s_ready && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign stat_frames = frames_q;
    assign stat_stall  = stall_q;
`else
    assign stat_frames = '0;
    assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed scenarios plus a random phase, checked every cycle against a queue-based reference model.
module tb_fft_frame_scheduler;

    localparam int NB_CH = 2;
    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NB_CH-1:0]     s_valid;
    logic [NB_CH-1:0]     s_ready;
    logic [NB_CH*8-1:0]   s_data;
    logic                 fft_s_valid;
    logic                 fft_s_ready;
    logic [63:0]          fft_x;
    logic                 fft_m_valid;
    logic                 fft_m_ready;
    logic                 m_valid;
    logic                 m_ready;
    logic [0:0]           m_ch;
    logic                 err_tag;
    logic [15:0]          stat_frames;
    logic [15:0]          stat_stall;

    fft_frame_scheduler #(.NUM_CH(NB_CH), .TAG_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fft_s_valid(fft_s_valid), .fft_s_ready(fft_s_ready), .fft_x(fft_x),
        .fft_m_valid(fft_m_valid), .fft_m_ready(fft_m_ready), .m_valid(m_valid),
        .m_ready(m_ready), .m_ch(m_ch), .err_tag(err_tag),
        .stat_frames(stat_frames), .stat_stall(stat_stall)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // stimulus for the next cycle
    bit                 rst_i;
    logic [NB_CH-1:0]   sv_i;
    logic [NB_CH*8-1:0] sd_i;
    bit                 fsr_i;
    bit                 mr_i;
    bit                 fmv_force;

    // reference model
    logic [7:0] acc [NB_CH][$];
    int         tags [$];
    int         core_due [$];
    int         cur = -1;
    int         rr = 0;
    bit         err = 0;
    int         frames = 0;
    int         stall = 0;
    bit         model_ok = 0;
    int         cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [NB_CH-1:0] exp_rdy;
        logic [63:0]      exp_x;
        bit               fmv;
        int               pick;
        int               ch;
        fmv = fmv_force || (core_due.size() > 0 && core_due[0] <= cyc);
        reset       = rst_i;
        s_valid     = sv_i;
        s_data      = sd_i;
        fft_s_ready = fsr_i;
        fft_m_valid = fmv;
        m_ready     = mr_i;
        #1;
        for (int c = 0; c < NB_CH; c++) exp_rdy[c] = !rst_i && (acc[c].size() != 8);
        if (model_ok) begin
            chk("s_ready", s_ready, exp_rdy);
            chk("fft_s_valid", fft_s_valid, cur >= 0);
            if (cur >= 0) begin
                exp_x = '0;
                for (int i = 0; i < 8; i++) exp_x[8*i +: 8] = acc[cur][i];
                chk("fft_x", fft_x, exp_x);
            end
            chk("m_ch", m_ch, (tags.size() > 0) ? tags[0] : 0);
            chk("err_tag", err_tag, err);
            chk("m_valid", m_valid, fmv);
            chk("fft_m_ready", fft_m_ready, mr_i);
`ifdef FFT_SCHED_STATS_EN
            chk("stat_frames", stat_frames, frames);
            chk("stat_stall", stat_stall, stall);
`else
            chk("stat_frames", stat_frames, 0);
            chk("stat_stall", stat_stall, 0);
`endif
        end
        if (rst_i) begin
            for (int c = 0; c < NB_CH; c++) acc[c].delete();
            tags.delete();
            core_due.delete();
            cur = -1; rr = 0; err = 0; frames = 0; stall = 0;
            model_ok = 1;
        end else if (model_ok) begin
            // Arbitration decision sees the state before this edge's updates.
            pick = -1;
            if (cur < 0 && tags.size() < DEPTH) begin
                for (int k = 0; k < NB_CH; k++) begin
                    ch = (rr + k) % NB_CH;
                    if (pick < 0 && acc[ch].size() == 8) pick = ch;
                end
            end
            if (fmv && tags.size() == 0) err = 1;
            if (fmv && mr_i && tags.size() > 0) void'(tags.pop_front());
            if (fmv && mr_i && core_due.size() > 0) void'(core_due.pop_front());
            if (cur >= 0) begin
                if (fsr_i) begin
                    tags.push_back(cur);
                    core_due.push_back(cyc + 3);
                    acc[cur].delete();
                    rr = (cur + 1) % NB_CH;
                    if (frames < 65535) frames++;
                    cur = -1;
                end else if (stall < 65535) begin
                    stall++;
                end
            end
            for (int c = 0; c < NB_CH; c++)
                if (sv_i[c] && exp_rdy[c]) acc[c].push_back(sd_i[8*c +: 8]);
            if (pick >= 0) cur = pick;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_i = 1; sv_i = '0; fsr_i = 0; mr_i = 0; fmv_force = 0;
        step();
        rst_i = 0;
    endtask

    task automatic rand_data();
        for (int c = 0; c < NB_CH; c++) sd_i[8*c +: 8] = 8'($urandom);
    endtask

    bit seen;

    initial begin
        sd_i = '0;
        do_reset();
        do_reset();

        // T1: single channel, samples 1..8
        fsr_i = 1; mr_i = 1;
        for (int i = 1; i <= 8; i++) begin
            sv_i = 2'b01; sd_i = '0; sd_i[7:0] = 8'(i);
            step();
        end
        sv_i = '0;
        chk("t1_not_yet", fft_s_valid, 0);
        step();
        chk("t1_valid", fft_s_valid, 1);
        chk("t1_x", fft_x, 64'h0807060504030201);
        step();
        chk("t1_one_cycle", fft_s_valid, 0);
        for (int i = 0; i < 8; i++) step();

        // T2: simultaneous completion, twice
        do_reset();
        fsr_i = 1; mr_i = 1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                sv_i = 2'b11; rand_data(); step();
            end
            sv_i = '0;
            for (int i = 0; i < 10; i++) step();
        end

        // T3: core backpressure for 5 issue cycles while ch1 fills
        do_reset();
        fsr_i = 0; mr_i = 1;
        for (int i = 0; i < 8; i++) begin
            sv_i = 2'b01; rand_data(); step();
        end
        sv_i = 2'b10;
        for (int i = 0; i < 6; i++) begin
            rand_data(); step();
        end
`ifdef FFT_SCHED_STATS_EN
        chk("t3_stall", stat_stall, 5);
`else
        chk("t3_stall", stat_stall, 0);
`endif
        chk("t3_held", fft_s_valid, 1);
        fsr_i = 1; sv_i = '0;
        for (int i = 0; i < 8; i++) step();

        // T4: credit limit with downstream stalled
        do_reset();
        fsr_i = 1; mr_i = 0;
        for (int i = 0; i < 60; i++) begin
            sv_i = 2'b11; rand_data(); step();
        end
        chk("t4_hold", fft_s_valid, 0);
        chk("t4_both_pending", s_ready, 2'b00);
        sv_i = '0; mr_i = 1;
        step();
        mr_i = 0; seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen |= fft_s_valid;
        end
        chk("t4_resume", seen, 1);

        // Random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NB_CH; c++) sv_i[c] = ($urandom_range(9) < 7);
            rand_data();
            fsr_i = ($urandom_range(3) != 0);
            mr_i  = ($urandom_range(9) > 2);
            step();
        end

        // T5: result with empty tag FIFO
        do_reset();
        sv_i = '0; mr_i = 1; fsr_i = 1; fmv_force = 1;
        step();
        fmv_force = 0;
        for (int i = 0; i < 3; i++) step();
        chk("t5_err", err_tag, 1);
        chk("t5_mch", m_ch, 0);

        // T6: reset with a partial frame and one frame in flight
        do_reset();
        fsr_i = 1; mr_i = 0;
        for (int i = 0; i < 8; i++) begin
            sv_i = 2'b01; rand_data(); step();
        end
        sv_i = '0;
        for (int i = 0; i < 3; i++) step();
        for (int i = 0; i < 5; i++) begin
            sv_i = 2'b01; rand_data(); step();
        end
        rst_i = 1; sv_i = '0;
        step();
        chk("t6_rdy_in_rst", s_ready, 2'b00);
        rst_i = 0;
        step();
        chk("t6_rdy_after", s_ready, 2'b11);
        chk("t6_valid", fft_s_valid, 0);
        chk("t6_mch", m_ch, 0);
        fmv_force = 1;
        step();
        fmv_force = 0;
        chk("t6_fifo_empty", err_tag, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
